// File: rtl/dmem_store_buf_if.sv
// Bus between the MEM stage / boot loader and the data memory with store buffer.
// Command semantics: there is no valid/ready pair. A command is presented for exactly
// one cycle via MEM_mem_cmd and is never back-pressured. Loads are answered in the same
// cycle on DM_mem_dout. Stores are accepted at the next rising edge unless the buffer is
// full with no drain, in which case they are dropped and DM_err_ovf is raised. ext_we is a
// single-cycle word write that always wins the array write port.
interface dmem_store_buf_if;
  logic [3:0]  MEM_mem_cmd;
  logic [31:0] MEM_mem_addr;
  logic [31:0] MEM_mem_din;
  logic [31:0] DM_mem_dout;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        DM_sb_full;
  logic        DM_sb_empty;
  logic        DM_err_misalign;
  logic        DM_err_ovf;

  modport master (
    output MEM_mem_cmd, MEM_mem_addr, MEM_mem_din, ext_we, ext_addr, ext_wdata,
    input  DM_mem_dout, DM_sb_full, DM_sb_empty, DM_err_misalign, DM_err_ovf
  );

  modport slave (
    input  MEM_mem_cmd, MEM_mem_addr, MEM_mem_din, ext_we, ext_addr, ext_wdata,
    output DM_mem_dout, DM_sb_full, DM_sb_empty, DM_err_misalign, DM_err_ovf
  );
endinterface

// File: rtl/dmem_store_buf.sv
// Data memory with a FIFO store buffer. Stores are queued and drain one per cycle
// into the word array; loads see the array merged with every buffered store.
module dmem_store_buf #(
  parameter int MEM_WORDS = 1024,
  parameter int SB_DEPTH  = 4
) (
  input logic             clk,
  input logic             rst,
  dmem_store_buf_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(SB_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(SB_DEPTH);

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   data;
  } sb_entry_t;

  logic [31:0]   mem [MEM_WORDS];
  sb_entry_t     sb [SB_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic          err_misalign;
  logic          err_ovf;

  logic [1:0]    op;
  logic [1:0]    size;
  logic          is_load;
  logic          is_store;
  logic          misalign;
  logic [AW-1:0] idx;
  logic [AW-1:0] ext_idx;
  logic [3:0]    new_be;
  logic [31:0]   new_data;
  logic          pop;
  logic          push;
  logic          drop;
  sb_entry_t     head_e;
  logic [31:0]   merged;

  assign op       = bus.MEM_mem_cmd[3:2];
  assign size     = bus.MEM_mem_cmd[1:0];
  assign is_load  = (op == 2'b01);
  assign is_store = (op == 2'b10);
  assign misalign = (is_load || is_store) &&
                    (((size == 2'b01) && bus.MEM_mem_addr[0]) ||
                     (size[1] && (bus.MEM_mem_addr[1:0] != 2'b00)));
  assign idx      = bus.MEM_mem_addr[AW+1:2];
  assign ext_idx  = bus.ext_addr[AW+1:2];
  assign head_e   = sb[head];

  // Upper address bits and the ignored ext_addr byte offset carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{bus.MEM_mem_addr[31:AW+2], bus.ext_addr[31:AW+2], bus.ext_addr[1:0]};

  // Lane placement: replicate the right-aligned store data so any enabled lane holds it.
  always_comb begin
    new_be   = 4'b1111;
    new_data = bus.MEM_mem_din;
    case (size)
      2'b00: begin
        new_be   = 4'b0001 << bus.MEM_mem_addr[1:0];
        new_data = {4{bus.MEM_mem_din[7:0]}};
      end
      2'b01: begin
        new_be   = bus.MEM_mem_addr[1] ? 4'b1100 : 4'b0011;
        new_data = {2{bus.MEM_mem_din[15:0]}};
      end
      default: begin
        new_be   = 4'b1111;
        new_data = bus.MEM_mem_din;
      end
    endcase
  end

  // The loader owns the array write port when active, so the drain stalls that cycle.
  // A drain in the same cycle frees a slot, letting a store enter a full buffer.
  assign pop  = rst && (count != '0) && !bus.ext_we;
  assign push = rst && is_store && !misalign && ((count != FULL_CNT) || pop);
  assign drop = rst && is_store && !misalign && (count == FULL_CNT) && !pop;

  // FIFO pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      err_misalign <= 1'b0;
      err_ovf      <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (misalign) err_misalign <= 1'b1;
      if (drop)     err_ovf      <= 1'b1;
    end
  end

  // Store-buffer entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (push) sb[tail] <= '{idx: idx, be: new_be, data: new_data};
  end

  // Array write port: loader word write, otherwise the head entry under its byte enables.
  always_ff @(posedge clk) begin
    if (bus.ext_we) begin
      mem[ext_idx] <= bus.ext_wdata;
    end else if (pop) begin
      for (int b = 0; b < 4; b++) begin
        if (head_e.be[b]) mem[head_e.idx][8*b +: 8] <= head_e.data[8*b +: 8];
      end
    end
  end

  // Load path: array word overlaid oldest-to-youngest so the youngest store wins per byte.
  always_comb begin
    merged = mem[idx];
    if (rst) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (((PW+1)'(i) < count) && (sb[head + PW'(i)].idx == idx)) begin
          for (int b = 0; b < 4; b++) begin
            if (sb[head + PW'(i)].be[b]) merged[8*b +: 8] = sb[head + PW'(i)].data[8*b +: 8];
          end
        end
      end
    end
  end

  assign bus.DM_mem_dout     = merged;
  assign bus.DM_sb_full      = (count == FULL_CNT);
  assign bus.DM_sb_empty     = (count == '0);
  assign bus.DM_err_misalign = err_misalign;
  assign bus.DM_err_ovf      = err_ovf;
endmodule

// File: tb/tb_dmem_store_buf.sv
// Bench for dmem_store_buf: directed scenarios followed by random traffic, all checked
// against a byte-level model built from a word array and a queue of pending stores.
module tb_dmem_store_buf;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  dmem_store_buf_if bus ();

  dmem_store_buf #(.MEM_WORDS(1024), .SB_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          widx;
    logic [7:0]  bytes [4];
    bit          en [4];
  } m_store_t;

  logic [31:0] ref_mem [1024];
  m_store_t    sb_q [$];
  logic        m_mis = 1'b0;
  logic        m_ovf = 1'b0;
  logic [31:0] last_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic r);
    logic [31:0] w;
    w = ref_mem[addr[11:2]];
    if (r) begin
      foreach (sb_q[i]) begin
        if (sb_q[i].widx == int'(addr[11:2])) begin
          for (int b = 0; b < 4; b++) if (sb_q[i].en[b]) w[8*b +: 8] = sb_q[i].bytes[b];
        end
      end
    end
    return w;
  endfunction

  task automatic model_update(input logic r, input logic [3:0] cmd, input logic [31:0] addr,
                              input logic [31:0] din, input logic we,
                              input logic [31:0] ea, input logic [31:0] ed);
    bit       mis;
    bit       do_pop;
    m_store_t e;
    int       base;
    if (we) ref_mem[ea[11:2]] = ed;
    if (!r) begin
      sb_q.delete();
      m_mis = 1'b0;
      m_ovf = 1'b0;
      return;
    end
    mis = ((cmd[3:2] == 2'b01) || (cmd[3:2] == 2'b10)) &&
          (((cmd[1:0] == 2'b01) && addr[0]) || ((cmd[1:0] >= 2'b10) && (addr[1:0] != 0)));
    do_pop = (sb_q.size() > 0) && !we;
    if (do_pop) begin
      e = sb_q.pop_front();
      for (int b = 0; b < 4; b++) if (e.en[b]) ref_mem[e.widx][8*b +: 8] = e.bytes[b];
    end
    if (mis) m_mis = 1'b1;
    if ((cmd[3:2] == 2'b10) && !mis) begin
      e.widx = int'(addr[11:2]);
      for (int b = 0; b < 4; b++) begin e.en[b] = 0; e.bytes[b] = 8'h00; end
      if (cmd[1:0] == 2'b00) begin
        e.en[addr[1:0]] = 1;
        e.bytes[addr[1:0]] = din[7:0];
      end else if (cmd[1:0] == 2'b01) begin
        base = addr[1] ? 2 : 0;
        e.en[base] = 1;     e.bytes[base]   = din[7:0];
        e.en[base+1] = 1;   e.bytes[base+1] = din[15:8];
      end else begin
        for (int b = 0; b < 4; b++) begin e.en[b] = 1; e.bytes[b] = din[8*b +: 8]; end
      end
      if (sb_q.size() < 4) sb_q.push_back(e);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] cmd, input logic [31:0] addr,
                      input logic [31:0] din, input logic we,
                      input logic [31:0] ea, input logic [31:0] ed);
    logic [31:0] exp;
    @(negedge clk);
    rst = r;
    bus.MEM_mem_cmd  = cmd;
    bus.MEM_mem_addr = addr;
    bus.MEM_mem_din  = din;
    bus.ext_we       = we;
    bus.ext_addr     = ea;
    bus.ext_wdata    = ed;
    #1;
    exp = model_read(addr, r);
    if (!$isunknown(exp)) check("dout", bus.DM_mem_dout, exp);
    last_dout = bus.DM_mem_dout;
    @(posedge clk);
    model_update(r, cmd, addr, din, we, ea, ed);
    #1;
    check("sb_full",  {31'b0, bus.DM_sb_full},      {31'b0, sb_q.size() == 4});
    check("sb_empty", {31'b0, bus.DM_sb_empty},     {31'b0, sb_q.size() == 0});
    check("err_mis",  {31'b0, bus.DM_err_misalign}, {31'b0, m_mis});
    check("err_ovf",  {31'b0, bus.DM_err_ovf},      {31'b0, m_ovf});
  endtask

  localparam logic [3:0] C_NONE = 4'b0000;
  localparam logic [3:0] C_LW   = 4'b0110;
  localparam logic [3:0] C_SW   = 4'b1010;
  localparam logic [3:0] C_SH   = 4'b1001;
  localparam logic [3:0] C_SB   = 4'b1000;

  initial begin
    logic [31:0] saved_a;
    logic [31:0] saved_b;
    logic [31:0] saved_c;
    logic [31:0] d3 [5];

    bus.MEM_mem_cmd  = C_NONE;
    bus.MEM_mem_addr = '0;
    bus.MEM_mem_din  = '0;
    bus.ext_we       = 1'b0;
    bus.ext_addr     = '0;
    bus.ext_wdata    = '0;

    // Reset, then preload the word region used by the bench through the loader port.
    step(1'b0, C_NONE, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b0, C_NONE, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    check("rst_empty", {31'b0, bus.DM_sb_empty}, 32'd1);
    check("rst_full",  {31'b0, bus.DM_sb_full},  32'd0);
    for (int i = 0; i < 64; i++) step(1'b1, C_NONE, 32'h0, 32'h0, 1'b1, i * 4, $urandom);

    // Store word then load it: forwarded, then from the array once drained.
    step(1'b1, C_SW, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
    step(1'b1, C_LW, 32'h10, 32'h0, 1'b0, 32'h0, 32'h0);
    check("t1_fwd", last_dout, 32'hDEADBEEF);
    step(1'b1, C_LW, 32'h10, 32'h0, 1'b0, 32'h0, 32'h0);
    check("t1_arr", last_dout, 32'hDEADBEEF);
    check("t1_empty", {31'b0, bus.DM_sb_empty}, 32'd1);

    // Loader word then byte store into lane 1.
    step(1'b1, C_NONE, 32'h0, 32'h0, 1'b1, 32'h20, 32'h11223344);
    step(1'b1, C_SB, 32'h21, 32'h000000AA, 1'b0, 32'h0, 32'h0);
    step(1'b1, C_LW, 32'h20, 32'h0, 1'b0, 32'h0, 32'h0);
    check("t2_lane1", last_dout, 32'h1122AA44);

    // Loader holds the port for 6 cycles while 5 stores arrive: fifth is dropped.
    saved_a = ref_mem[32'h60 >> 2];
    for (int i = 0; i < 5; i++) begin
      d3[i] = $urandom;
      step(1'b1, C_SW, 32'h50 + i * 4, d3[i], 1'b1, 32'h80, 32'hCAFE0000 + i);
      if (i == 3) check("t3_full", {31'b0, bus.DM_sb_full}, 32'd1);
    end
    check("t3_ovf", {31'b0, bus.DM_err_ovf}, 32'd1);
    step(1'b1, C_NONE, 32'h0, 32'h0, 1'b1, 32'h80, 32'hCAFE0005);
    for (int i = 0; i < 3; i++) step(1'b1, C_NONE, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    check("t3_not_empty", {31'b0, bus.DM_sb_empty}, 32'd0);
    step(1'b1, C_NONE, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    check("t3_empty", {31'b0, bus.DM_sb_empty}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, C_LW, 32'h50 + i * 4, 32'h0, 1'b0, 32'h0, 32'h0);
      check("t3_drained", last_dout, d3[i]);
    end
    step(1'b1, C_LW, 32'h60, 32'h0, 1'b0, 32'h0, 32'h0);
    check("t3_dropped", last_dout, saved_a);

    // Misaligned halfword store is rejected and flagged.
    saved_a = ref_mem[32'h30 >> 2];
    step(1'b1, C_SH, 32'h33, 32'h0000BEEF, 1'b0, 32'h0, 32'h0);
    check("t4_mis", {31'b0, bus.DM_err_misalign}, 32'd1);
    check("t4_empty", {31'b0, bus.DM_sb_empty}, 32'd1);
    step(1'b1, C_LW, 32'h30, 32'h0, 1'b0, 32'h0, 32'h0);
    check("t4_untouched", last_dout, saved_a);

    // Two byte stores to one lane with drain stalled: the younger wins.
    saved_a = ref_mem[32'h40 >> 2];
    step(1'b1, C_SB, 32'h40, 32'h01, 1'b1, 32'h84, 32'h0);
    step(1'b1, C_SB, 32'h40, 32'h02, 1'b1, 32'h84, 32'h0);
    step(1'b1, C_LW, 32'h40, 32'h0, 1'b1, 32'h84, 32'h0);
    check("t5_fwd", last_dout, {saved_a[31:8], 8'h02});
    step(1'b1, C_NONE, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, C_NONE, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, C_LW, 32'h40, 32'h0, 1'b0, 32'h0, 32'h0);
    check("t5_arr", last_dout, {saved_a[31:8], 8'h02});

    // Reset with three buffered stores discards them.
    saved_a = ref_mem[32'h90 >> 2];
    saved_b = ref_mem[32'h94 >> 2];
    saved_c = ref_mem[32'h98 >> 2];
    for (int i = 0; i < 3; i++) step(1'b1, C_SW, 32'h90 + i * 4, $urandom, 1'b1, 32'h88, 32'h0);
    step(1'b0, C_NONE, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    check("t6_empty", {31'b0, bus.DM_sb_empty}, 32'd1);
    check("t6_mis",   {31'b0, bus.DM_err_misalign}, 32'd0);
    check("t6_ovf",   {31'b0, bus.DM_err_ovf}, 32'd0);
    step(1'b1, C_LW, 32'h90, 32'h0, 1'b0, 32'h0, 32'h0);
    check("t6_a", last_dout, saved_a);
    step(1'b1, C_LW, 32'h94, 32'h0, 1'b0, 32'h0, 32'h0);
    check("t6_b", last_dout, saved_b);
    step(1'b1, C_LW, 32'h98, 32'h0, 1'b0, 32'h0, 32'h0);
    check("t6_c", last_dout, saved_c);

    // Random traffic over a small address window so forwarding hits are frequent.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) != 0), 4'($urandom_range(0, 15)), 32'($urandom_range(0, 255)),
           $urandom, ($urandom_range(0, 4) == 0), 32'($urandom_range(0, 255)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
